my_boot_sequencer: RTL and testbench

//  Boot controller for the Hack computer. Holds the CPU in reset and loads the

---
 rtl/my_boot_pkg.sv | 26 ++
 rtl/my_boot_watchdog.sv | 38 +++
 rtl/my_boot_sequencer.sv | 146 ++++++++++++++
 tb/tb_my_boot_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/my_boot_pkg.sv
// Shared types and constants for the Hack boot sequencer.
package my_boot_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 2;
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned COUNT_W        = HDR_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DAT_HI,
        ST_DAT_LO,
        ST_WRITE,
        ST_RUN,
        ST_ERROR
    } boot_state_t;

    // States in which a byte may be taken from the link.
    function automatic logic is_rx_state(input boot_state_t s);
        return (s == ST_HDR_HI) || (s == ST_HDR_LO) ||
               (s == ST_DAT_HI) || (s == ST_DAT_LO);
    endfunction

endpackage

// File: rtl/my_boot_watchdog.sv
// Idle-cycle counter for the byte link; flags expiry after TIMEOUT_CYC idle cycles.
module my_boot_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;

    // Saturates at the limit; a zero limit never counts and never expires.
    always_comb begin
        timer_nxt = timer;
        if (clear) begin
            timer_nxt = '0;
        end else if (enable && (timer != LIMIT)) begin
            timer_nxt = timer + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer   <= '0;
            expired <= 1'b0;
        end else begin
            timer   <= timer_nxt;
            expired <= (TIMEOUT_CYC != 0) && (timer_nxt == LIMIT);
        end
    end

endmodule

// File: rtl/my_boot_sequencer.sv
// Boot controller: holds the Hack CPU in reset while loading ROM from a
// big-endian byte stream (word count, then words), then releases it.
module my_boot_sequencer
    import my_boot_pkg::*;
#(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned DATA_W      = BYTES_PER_WORD * BYTE_W,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_wr_en,
    output logic [ADDR_W-1:0] rom_wr_addr,
    output logic [DATA_W-1:0] rom_wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    boot_state_t        state;
    boot_state_t        state_nxt;
    logic [BYTE_W-1:0]  count_hi;
    logic [BYTE_W-1:0]  data_hi;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] count_c;
    logic               accept_c;
    logic               restart_c;
    logic               wd_clear_c;
    logic               wd_enable_c;
    logic               expired;

    assign accept_c    = rx_valid && rx_ready;
    assign count_c     = {count_hi, rx_data};
    assign restart_c   = boot_start &&
                         ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERROR));
    // Timer restarts on every byte and is held at zero outside a load; frozen in WRITE.
    assign wd_clear_c  = accept_c || (state == ST_IDLE) || (state == ST_RUN) ||
                         (state == ST_ERROR);
    assign wd_enable_c = is_rx_state(state);

    my_boot_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear_c),
        .enable  (wd_enable_c),
        .expired (expired)
    );

    // Next-state logic; a byte arriving on the expiry cycle still wins.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (boot_start) state_nxt = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (accept_c)     state_nxt = ST_HDR_LO;
                else if (expired) state_nxt = ST_ERROR;
            end
            ST_HDR_LO: begin
                if (accept_c) begin
                    if (count_c == '0)                  state_nxt = ST_RUN;
                    else if (32'(count_c) > MAX_WORDS)  state_nxt = ST_ERROR;
                    else                                state_nxt = ST_DAT_HI;
                end else if (expired) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_DAT_HI: begin
                if (accept_c)     state_nxt = ST_DAT_LO;
                else if (expired) state_nxt = ST_ERROR;
            end
            ST_DAT_LO: begin
                if (accept_c)     state_nxt = ST_WRITE;
                else if (expired) state_nxt = ST_ERROR;
            end
            ST_WRITE: begin
                state_nxt = (remaining == COUNT_W'(1)) ? ST_RUN : ST_DAT_HI;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register with Moore outputs registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rx_ready  <= 1'b0;
            rom_wr_en <= 1'b0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            rx_ready  <= is_rx_state(state_nxt);
            rom_wr_en <= (state_nxt == ST_WRITE);
            cpu_reset <= (state_nxt != ST_RUN);
            busy      <= is_rx_state(state_nxt) || (state_nxt == ST_WRITE);
            done      <= (state_nxt == ST_RUN);
            error     <= (state_nxt == ST_ERROR);
        end
    end

    // Header capture, word assembly and the address/word counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_hi     <= '0;
            data_hi      <= '0;
            remaining    <= '0;
            rom_wr_addr  <= '0;
            rom_wr_data  <= '0;
            words_loaded <= '0;
        end else begin
            if (restart_c) begin
                rom_wr_addr  <= '0;
                words_loaded <= '0;
            end
            if (accept_c) begin
                case (state)
                    ST_HDR_HI: count_hi    <= rx_data;
                    ST_HDR_LO: remaining   <= count_c;
                    ST_DAT_HI: data_hi     <= rx_data;
                    ST_DAT_LO: rom_wr_data <= DATA_W'({data_hi, rx_data});
                    default: ;
                endcase
            end
            if (state == ST_WRITE) begin
                rom_wr_addr  <= rom_wr_addr + ADDR_W'(1);
                words_loaded <= words_loaded + 16'd1;
                remaining    <= remaining - COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_my_boot_sequencer.sv
// Scoreboard bench for my_boot_sequencer: expected ROM writes are queued by
// the stimulus and consumed by an independent write monitor.
module tb_my_boot_sequencer;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;

    logic              clk;
    logic              reset;
    logic              boot_start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rom_wr_en;
    logic [ADDR_W-1:0] rom_wr_addr;
    logic [DATA_W-1:0] rom_wr_data;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int busy_cycles = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    my_boot_sequencer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .boot_start   (boot_start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rom_wr_en    (rom_wr_en),
        .rom_wr_addr  (rom_wr_addr),
        .rom_wr_data  (rom_wr_data),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (rom_wr_en === 1'b1) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rom_write: unexpected write addr %0h data %0h", rom_wr_addr, rom_wr_data);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                if ({rom_wr_addr, rom_wr_data} !== e) begin
                    errors++;
                    $display("FAIL rom_write: got addr %0h data %0h expected addr %0h data %0h",
                             rom_wr_addr, rom_wr_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic expect_write(input int a, input logic [15:0] d);
        exp_q.push_back({ADDR_W'(a), d});
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int budget;
        budget = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_gap(input logic [7:0] b, input int gap, input bit pulse);
        rx_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            boot_start = pulse && (i == 0);
            @(negedge clk);
        end
        boot_start = 1'b0;
        send_byte(b);
    endtask

    task automatic pulse_start();
        boot_start = 1'b1;
        @(negedge clk);
        boot_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int budget;
        budget = 0;
        rx_valid = 1'b0;
        while (done !== 1'b1 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        int wr_before;
        int first_err;
        logic [7:0] img [8];

        reset = 1'b0; boot_start = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_flags", {busy, done, error, rom_wr_en}, 32'd0);
        check("rst_addr_data", {rom_wr_addr, rom_wr_data}, 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);

        // Idle 100 cycles without a start.
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_cpu_reset", 32'(cpu_reset), 32'd1);
        check("idle_rx_ready", 32'(rx_ready), 32'd0);
        check("idle_writes", 32'(wr_cnt), 32'd0);

        // Three-word image, back-to-back.
        busy_cycles = 0;
        expect_write(0, 16'h1234); expect_write(1, 16'hABCD); expect_write(2, 16'h7FFF);
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h7F); send_byte(8'hFF);
        wait_done("img3_done");
        check("img3_busy_cycles", 32'(busy_cycles), 32'd11);
        check("img3_cpu_reset", 32'(cpu_reset), 32'd0);
        check("img3_words", 32'(words_loaded), 32'd3);
        check("img3_drain", 32'(exp_q.size()), 32'd0);

        // Restart from RUN with an empty image.
        pulse_start();
        check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        check("restart_words", 32'(words_loaded), 32'd0);
        wr_before = wr_cnt;
        send_byte(8'h00); send_byte(8'h00);
        rx_valid = 1'b0;
        check("empty_done", 32'(done), 32'd1);
        check("empty_words", 32'(words_loaded), 32'd0);
        check("empty_writes", 32'(wr_cnt - wr_before), 32'd0);

        // Oversize count (2**15 + 1).
        pulse_start();
        send_byte(8'h80); send_byte(8'h01);
        rx_valid = 1'b0;
        check("oversize_error", 32'(error), 32'd1);
        check("oversize_cpu_reset", 32'(cpu_reset), 32'd1);
        check("oversize_flags", {busy, done, rx_ready}, 32'd0);
        check("oversize_writes", 32'(wr_cnt - wr_before), 32'd0);

        // Stall after the first data byte until the watchdog fires.
        pulse_start();
        check("err_cleared", 32'(error), 32'd0);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h11);
        rx_valid = 1'b0;
        first_err = -1;
        for (int i = 1; i <= 14; i++) begin
            if (error === 1'b1 && first_err < 0) first_err = i;
            @(negedge clk);
        end
        check("timeout_not_early", 32'(first_err >= 8), 32'd1);
        check("timeout_not_late", 32'(first_err <= 10 && first_err > 0), 32'd1);
        check("timeout_writes", 32'(wr_cnt - wr_before), 32'd0);

        // Recovery load starts again at address 0.
        expect_write(0, 16'hA55A); expect_write(1, 16'h0FF0);
        pulse_start();
        check("recover_error", 32'(error), 32'd0);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hA5); send_byte(8'h5A);
        send_byte(8'h0F); send_byte(8'hF0);
        wait_done("recover_done");
        check("recover_words", 32'(words_loaded), 32'd2);

        // Gappy stream with ignored mid-load starts.
        img = '{8'h00, 8'h01, 8'h80, 8'h00, 8'hFF, 8'hFF, 8'hC3, 8'hC3};
        expect_write(0, 16'h0001); expect_write(1, 16'h8000);
        expect_write(2, 16'hFFFF); expect_write(3, 16'hC3C3);
        pulse_start();
        send_gap(8'h00, int'($urandom_range(0, 3)), 1'b0);
        send_gap(8'h04, 1, 1'b1);
        for (int i = 0; i < 8; i++)
            send_gap(img[i], int'($urandom_range(1, 3)), (i % 3) == 1);
        wait_done("gappy_done");
        check("gappy_words", 32'(words_loaded), 32'd4);
        check("gappy_drain", 32'(exp_q.size()), 32'd0);

        // Async reset part-way through a load.
        expect_write(0, 16'h1122);
        pulse_start();
        send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        #2 reset = 1'b0;
        #1;
        check("async_cpu_reset", 32'(cpu_reset), 32'd1);
        check("async_flags", {busy, rx_ready, done, error}, 32'd0);
        check("async_addr_words", {rom_wr_addr, words_loaded}, 32'd0);
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wr_before = wr_cnt;
        repeat (20) @(negedge clk);
        check("post_reset_writes", 32'(wr_cnt - wr_before), 32'd0);
        check("post_reset_cpu", 32'(cpu_reset), 32'd1);
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
